branch_predictor_bht: RTL and testbench
=======================================

// Module: branch_predictor_bht
// PURPOSE
//  Parametrised branch direction predictor that replaces the single 2-bit FSM predictor in the RV32I pipeline.
//  It holds a table of saturating counters, indexed by PC or by PC XOR global history (gshare).
//  It is looked up combinationally in decode (ID) and trained when the branch resolves in MEM.
//  It also keeps performance counters for branches and mispredicts.
// PARAMETERS
//  INDEX_BITS  6   log2 table depth; entry index = pc[INDEX_BITS+1:2]
//  CTR_BITS    2   saturating counter width (>=1)
//  GHR_BITS    0   global history length; 0 = bimodal, 1..INDEX_BITS = gshare
//  PERF_BITS   32  width of the performance counters
// PORTS
//  clk_i            in   1           clock, all state updates on rising edge
//  rstn_i           in   1           async active-low reset
//  lookup_valid_i   in   1           ID stage holds a conditional branch
//  lookup_pc_i      in   32          PC of the branch in ID
//  lookup_offset_i  in   32          sign-extended B-type immediate
//  predict_o        out  1           1 = predict taken
//  target_o         out  32          predicted target address
//  lookup_idx_o     out  INDEX_BITS  table index used; carried down the pipe to MEM
//  update_valid_i   in   1           MEM stage holds a resolved conditional branch
//  update_idx_i     in   INDEX_BITS  index captured at lookup time
//  update_taken_i   in   1           actual branch outcome
//  update_mispred_i in   1           prediction was wrong
//  branch_cnt_o     out  PERF_BITS   resolved branches since reset
//  mispred_cnt_o    out  PERF_BITS   mispredicts since reset
// BEHAVIOUR
//  - Reset (async, rstn_i=0):
//    - every counter = 2^(CTR_BITS-1)-1 (weakly not-taken), GHR = 0, both perf counters = 0.
//    - predict_o is therefore 0 for any lookup until training occurs.
//  - Lookup (combinational, zero latency):
//    - idx = pc[INDEX_BITS+1:2], XOR {GHR, zero-padded at the MSBs} when GHR_BITS>0.
//    - lookup_idx_o = idx at all times.
//    - predict_o = lookup_valid_i & ctr[idx][CTR_BITS-1].
//    - target_o = lookup_pc_i + lookup_offset_i, mod 2^32, wraps silently.
//  - Update (registered, takes effect next cycle), when update_valid_i=1:
//    - ctr[update_idx_i] +1 if update_taken_i, else -1.
//    - Saturates at 2^CTR_BITS-1 and at 0; no wrap.
//    - GHR <= {GHR[GHR_BITS-2:0], update_taken_i}. The GHR is updated non-speculatively, at resolve only.
//    - branch_cnt_o +1.
//    - mispred_cnt_o +1 when update_mispred_i=1.
//    - Both perf counters saturate at all-ones.
//  - When update_valid_i=0: no state changes. update_taken_i and update_mispred_i are ignored.
//  - Same-cycle lookup and update to the same index:
//    - The lookup sees the pre-update counter value (no bypass).
//    - The new value is visible from the next cycle.
//  - Lookup idx vs update idx: the lookup idx uses the current GHR, so a same-cycle GHR shift affects the next lookup only.
//  - Aliasing: PCs that share idx share a counter. No tags.
//  - Async reset mid-operation: all state returns to reset values immediately. The first update after deassert applies normally.
//  - One update per cycle maximum. Pipeline flushes need no signal: an unresolved lookup simply never updates.
// TESTING
//  1. Reset, then lookup pc=0x40 valid -> predict_o=0, target_o=0x40+offset, lookup_idx_o=0x10.
//  2. Defaults: 1 taken update at idx 0x10 -> next-cycle lookup 0x40 predict_o=1.
//     3 not-taken updates -> predict_o=0. Counter sits at 0: a 4th not-taken changes nothing.
//  3. Saturation: 5 taken updates at idx 0x10, then 1 not-taken -> predict_o still 1.
//     Lookup pc=0x140 (aliases to idx 0x10) -> predict_o=1.
//  4. Same cycle: lookup 0x40 with update idx 0x10 taken, from reset state -> predict_o=0 this cycle, 1 next cycle.
//  5. GHR_BITS=4, 4 taken updates: after 4 taken resolves GHR=0xF. Lookup pc=0x40 -> lookup_idx_o=0x1F.
//  6. Perf and wrap:
//     - 10 updates with 3 mispred -> branch_cnt_o=10, mispred_cnt_o=3.
//     - Pulse rstn_i low mid-stream -> both 0 and predict_o=0 without a clock edge.
//     - PC=0xFFFFFFF0 with offset 0x20 -> target_o=0x10.

Source files
------------

// File: rtl/branch_predictor_bht_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht_if : lookup / update / perf-counter bus for the BHT
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface branch_predictor_bht_if #(
  parameter int INDEX_BITS = 6,
  parameter int PERF_BITS  = 32
);
  logic                  lookup_valid_i;
  logic [31:0]           lookup_pc_i;
  logic [31:0]           lookup_offset_i;
  logic                  predict_o;
  logic [31:0]           target_o;
  logic [INDEX_BITS-1:0] lookup_idx_o;
  logic                  update_valid_i;
  logic [INDEX_BITS-1:0] update_idx_i;
  logic                  update_taken_i;
  logic                  update_mispred_i;
  logic [PERF_BITS-1:0]  branch_cnt_o;
  logic [PERF_BITS-1:0]  mispred_cnt_o;

  modport slave (
    input  lookup_valid_i, lookup_pc_i, lookup_offset_i,
    input  update_valid_i, update_idx_i, update_taken_i, update_mispred_i,
    output predict_o, target_o, lookup_idx_o, branch_cnt_o, mispred_cnt_o
  );

  modport master (
    output lookup_valid_i, lookup_pc_i, lookup_offset_i,
    output update_valid_i, update_idx_i, update_taken_i, update_mispred_i,
    input  predict_o, target_o, lookup_idx_o, branch_cnt_o, mispred_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht : bimodal/gshare saturating-counter direction predictor
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module branch_predictor_bht #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 0,
  parameter int PERF_BITS  = 32
) (
  input wire logic               clk_i,
  input wire logic               rstn_i,
  branch_predictor_bht_if.slave  bus
);

  localparam int                 c_DEPTH    = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] c_CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] c_CTR_MAX  = '1;

  logic [CTR_BITS-1:0]   r_ctr [c_DEPTH];
  logic [PERF_BITS-1:0]  r_branch_cnt;
  logic [PERF_BITS-1:0]  r_mispred_cnt;

  logic [INDEX_BITS-1:0] w_pc_idx;
  logic [INDEX_BITS-1:0] w_ghr_mix;
  logic [INDEX_BITS-1:0] w_idx;
  logic [CTR_BITS-1:0]   w_ctr_cur;
  logic [CTR_BITS-1:0]   w_ctr_nxt;

  assign w_pc_idx = bus.lookup_pc_i[INDEX_BITS+1:2];

  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] r_ghr;

      // Shift only at resolve time so wrong-path branches never pollute history.
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          r_ghr <= '0;
        end else if (bus.update_valid_i) begin
          r_ghr <= GHR_BITS'({r_ghr, bus.update_taken_i});
        end
      end

      assign w_ghr_mix = INDEX_BITS'(r_ghr);
    end else begin : g_no_ghr
      assign w_ghr_mix = '0;
    end
  endgenerate

  assign w_idx            = w_pc_idx ^ w_ghr_mix;
  assign bus.lookup_idx_o = w_idx;
  assign bus.predict_o    = bus.lookup_valid_i & r_ctr[w_idx][CTR_BITS-1];
  assign bus.target_o     = bus.lookup_pc_i + bus.lookup_offset_i;

  assign w_ctr_cur = r_ctr[bus.update_idx_i];

  always_comb begin
    w_ctr_nxt = w_ctr_cur;
    if (bus.update_taken_i) begin
      if (w_ctr_cur != c_CTR_MAX) w_ctr_nxt = w_ctr_cur + 1'b1;
    end else begin
      if (w_ctr_cur != '0) w_ctr_nxt = w_ctr_cur - 1'b1;
    end
  end

  // Lookup reads the pre-update value; the write lands at the edge (no bypass).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < c_DEPTH; i++) r_ctr[i] <= c_CTR_INIT;
    end else if (bus.update_valid_i) begin
      r_ctr[bus.update_idx_i] <= w_ctr_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (bus.update_valid_i) begin
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
      if (bus.update_mispred_i && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign bus.branch_cnt_o  = r_branch_cnt;
  assign bus.mispred_cnt_o = r_mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_bht : vector-table + scoreboard bench for the BHT
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_branch_predictor_bht;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  branch_predictor_bht_if #(.INDEX_BITS(6), .PERF_BITS(32)) bus_a ();
  branch_predictor_bht_if #(.INDEX_BITS(6), .PERF_BITS(3))  bus_b ();

  branch_predictor_bht #(.INDEX_BITS(6), .CTR_BITS(2), .GHR_BITS(0), .PERF_BITS(32)) dut_a (
    .clk_i (clk), .rstn_i (rstn), .bus (bus_a)
  );

  branch_predictor_bht #(.INDEX_BITS(6), .CTR_BITS(2), .GHR_BITS(4), .PERF_BITS(3)) dut_b (
    .clk_i (clk), .rstn_i (rstn), .bus (bus_b)
  );

  typedef struct {
    logic        lv;
    logic [31:0] pc;
    logic [31:0] off;
    logic        uv;
    logic [5:0]  ui;
    logic        ut;
    logic        um;
    logic        ep;
    logic [31:0] et;
    logic [5:0]  ei;
  } vec_t;

  typedef struct {
    int          id;
    logic        p;
    logic [31:0] t;
    logic [5:0]  i;
  } exp_t;

  localparam int c_NVEC = 20;
  vec_t vecs [c_NVEC];
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic lv, input logic [31:0] pc, input logic [31:0] off,
                              input logic uv, input logic [5:0] ui, input logic ut, input logic um,
                              input logic ep, input logic [31:0] et, input logic [5:0] ei);
    vec_t v;
    v.lv = lv; v.pc = pc; v.off = off; v.uv = uv; v.ui = ui; v.ut = ut; v.um = um;
    v.ep = ep; v.et = et; v.ei = ei;
    return v;
  endfunction

  task automatic drive_a(input vec_t v);
    bus_a.lookup_valid_i   = v.lv;
    bus_a.lookup_pc_i      = v.pc;
    bus_a.lookup_offset_i  = v.off;
    bus_a.update_valid_i   = v.uv;
    bus_a.update_idx_i     = v.ui;
    bus_a.update_taken_i   = v.ut;
    bus_a.update_mispred_i = v.um;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [3:0]  ghr_m;
    logic        t;

    // Bimodal table: each row is one cycle; expectations are pre-update state.
    //          lv  pc            off           uv  ui     ut  um   ep  et            ei
    vecs[0]  = mk(1, 32'h40,       32'h100,      0, 6'h00, 0, 0,  0, 32'h140,      6'h10);
    vecs[1]  = mk(1, 32'h40,       32'h4,        1, 6'h10, 1, 1,  0, 32'h44,       6'h10);
    vecs[2]  = mk(1, 32'h40,       32'h4,        1, 6'h10, 0, 1,  1, 32'h44,       6'h10);
    vecs[3]  = mk(1, 32'h40,       32'h4,        1, 6'h10, 0, 0,  0, 32'h44,       6'h10);
    vecs[4]  = mk(1, 32'h40,       32'h4,        1, 6'h10, 0, 0,  0, 32'h44,       6'h10);
    vecs[5]  = mk(1, 32'h40,       32'h4,        1, 6'h10, 0, 0,  0, 32'h44,       6'h10);
    vecs[6]  = mk(1, 32'h40,       32'h4,        1, 6'h10, 1, 0,  0, 32'h44,       6'h10);
    vecs[7]  = mk(0, 32'h40,       32'h4,        1, 6'h10, 1, 0,  0, 32'h44,       6'h10);
    vecs[8]  = mk(1, 32'h40,       32'h4,        0, 6'h00, 0, 0,  1, 32'h44,       6'h10);
    vecs[9]  = mk(1, 32'h40,       32'h4,        1, 6'h10, 1, 0,  1, 32'h44,       6'h10);
    vecs[10] = mk(1, 32'h40,       32'h4,        1, 6'h10, 1, 0,  1, 32'h44,       6'h10);
    vecs[11] = mk(1, 32'h40,       32'h4,        1, 6'h10, 1, 0,  1, 32'h44,       6'h10);
    vecs[12] = mk(1, 32'h40,       32'h4,        1, 6'h10, 1, 0,  1, 32'h44,       6'h10);
    vecs[13] = mk(1, 32'h40,       32'h4,        1, 6'h10, 0, 0,  1, 32'h44,       6'h10);
    vecs[14] = mk(1, 32'h140,      32'h4,        0, 6'h00, 0, 0,  1, 32'h144,      6'h10);
    vecs[15] = mk(1, 32'h40,       32'h4,        0, 6'h10, 0, 1,  1, 32'h44,       6'h10);
    vecs[16] = mk(1, 32'h40,       32'h4,        0, 6'h00, 0, 0,  1, 32'h44,       6'h10);
    vecs[17] = mk(1, 32'hFFFFFFF0, 32'h20,       0, 6'h00, 0, 0,  0, 32'h10,       6'h3C);
    vecs[18] = mk(1, 32'h44,       32'h4,        1, 6'h11, 1, 0,  0, 32'h48,       6'h11);
    vecs[19] = mk(1, 32'h44,       32'h4,        0, 6'h00, 0, 0,  1, 32'h48,       6'h11);

    rstn = 1'b0;
    drive_a(mk(1, 32'h40, 32'h0, 0, 6'h00, 0, 0, 0, 32'h0, 6'h0));
    bus_b.lookup_valid_i   = 1'b1;
    bus_b.lookup_pc_i      = 32'h40;
    bus_b.lookup_offset_i  = 32'h0;
    bus_b.update_valid_i   = 1'b0;
    bus_b.update_idx_i     = 6'h05;
    bus_b.update_taken_i   = 1'b0;
    bus_b.update_mispred_i = 1'b0;
    #2;
    chk("reset.predict",     32'(bus_a.predict_o),   32'h0);
    chk("reset.idx",         32'(bus_a.lookup_idx_o), 32'h10);
    chk("reset.branch_cnt",  bus_a.branch_cnt_o,     32'h0);
    chk("reset.mispred_cnt", bus_a.mispred_cnt_o,    32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int k = 0; k < c_NVEC; k++) begin
      @(posedge clk); #1;
      drive_a(vecs[k]);
      sb.push_back('{id: k, p: vecs[k].ep, t: vecs[k].et, i: vecs[k].ei});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d.predict", e.id), 32'(bus_a.predict_o),    32'(e.p));
      chk($sformatf("v%0d.target",  e.id), bus_a.target_o,          e.t);
      chk($sformatf("v%0d.idx",     e.id), 32'(bus_a.lookup_idx_o), 32'(e.i));
    end

    @(posedge clk); #1;
    drive_a(mk(1, 32'h40, 32'h4, 0, 6'h00, 0, 0, 0, 32'h0, 6'h0));
    #1;
    chk("table.branch_cnt",  bus_a.branch_cnt_o,  32'd13);
    chk("table.mispred_cnt", bus_a.mispred_cnt_o, 32'd2);
    chk("prereset.predict",  32'(bus_a.predict_o), 32'h1);

    // Asynchronous reset with no clock edge in between.
    rstn = 1'b0;
    #1;
    chk("async_rst.predict",     32'(bus_a.predict_o), 32'h0);
    chk("async_rst.branch_cnt",  bus_a.branch_cnt_o,   32'h0);
    chk("async_rst.mispred_cnt", bus_a.mispred_cnt_o,  32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive_a(mk(1, 32'h40, 32'h4, 1, 6'h10, 1, (i < 3), 0, 32'h0, 6'h0));
      @(negedge clk);
      chk($sformatf("post_rst%0d.predict", i), 32'(bus_a.predict_o), 32'(i >= 1));
    end
    @(posedge clk); #1;
    bus_a.update_valid_i = 1'b0;
    #1;
    chk("perf.branch_cnt",  bus_a.branch_cnt_o,  32'd10);
    chk("perf.mispred_cnt", bus_a.mispred_cnt_o, 32'd3);

    // gshare instance: 4 taken then 6 not-taken, 3-bit saturating perf counters.
    ghr_m = 4'h0;
    for (int i = 0; i < 10; i++) begin
      t = (i < 4);
      @(posedge clk); #1;
      bus_b.update_valid_i   = 1'b1;
      bus_b.update_taken_i   = t;
      bus_b.update_mispred_i = (i < 3);
      @(negedge clk);
      chk($sformatf("gshare%0d.idx", i), 32'(bus_b.lookup_idx_o), 32'(6'h10 ^ {2'b00, ghr_m}));
      if (i == 4) chk("gshare.ghr_full_idx", 32'(bus_b.lookup_idx_o), 32'h1F);
      ghr_m = {ghr_m[2:0], t};
    end
    @(posedge clk); #1;
    bus_b.update_valid_i = 1'b0;
    #1;
    chk("gshare.final_idx",   32'(bus_b.lookup_idx_o),  32'h10);
    chk("gshare.branch_sat",  32'(bus_b.branch_cnt_o),  32'd7);
    chk("gshare.mispred_cnt", 32'(bus_b.mispred_cnt_o), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
